gtb_tracker: RTL and testbench
==============================

# gtb_tracker

Gray-to-binary receive-side tracker, the decode end of the team's binary-to-gray (`btg`) path. It accepts an asynchronous W-bit Gray-coded position and passes it through a 2-flop synchronizer. It then decodes the position to binary, classifies each change as a legal single step up or down, or as an illegal jump. It keeps a signed running position and a saturating error count for downstream control logic.

## Interface
- `W`, 4: Gray/binary code width; legal range is 2 to 8.
- `P`, 16: position accumulator width, two's complement.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `g_in` input W: Gray code from the sender, asynchronous to `clk`.
- `clr` input 1: synchronous clear of `pos`, `err_cnt` and the FAULT state.
- `bin` output W: last accepted decoded binary value.
- `step` output 1: one-cycle pulse marking a legal ±1 change.
- `dir` output 1: direction of the last step; 1 = up (+1), 0 = down (−1). Held between steps.
- `pos` output P: signed step accumulator.
- `err` output 1: one-cycle pulse marking an illegal change.
- `fault` output 1: high while the FSM is in FAULT.
- `err_cnt` output 8: count of illegal changes, saturating at 255.

## Operation
- **Synchronizer:** `s1 <= g_in`, `s2 <= s1`; both reset to 0. Decode is combinational: `cur[W-1] = s2[W-1]` and `cur[i] = cur[i+1] ^ s2[i]`.
- **Internal state:** `prev` holds the last accepted value and drives `bin`.
- **Reset values:** `bin`=0, `step`=0, `dir`=0, `pos`=0, `err`=0, `fault`=0, `err_cnt`=0, FSM in INIT with flush counter at 0.
- **INIT:** waits 2 cycles for the synchronizer to flush. It then loads `prev <= cur` with no `step` or `err` and moves to TRACK. Changes on `g_in` during INIT never produce steps.
- **TRACK:**
  - `cur == prev`: no action.
  - `cur == prev+1` (mod 2^W): `step`=1, `dir`=1, `pos <= pos+1`, `prev <= cur`.
  - `cur == prev−1` (mod 2^W): `step`=1, `dir`=0, `pos <= pos−1`, `prev <= cur`.
  - Any other change: `err`=1, `err_cnt` increments (saturating), `prev <= cur` (resync), `pos` unchanged, next state FAULT.
- **FAULT:** `fault`=1. `prev`/`bin` keep following `cur`, but `step` stays 0 and `pos` is frozen. Further illegal changes pulse `err` and increment `err_cnt`. Legal changes are silent.
- **`clr`:**
  - In any state other than INIT: `pos <= 0`, `err_cnt <= 0`, `prev <= cur`, next state TRACK.
  - In INIT: ignored.
  - `clr` wins over a same-cycle step or error, so no `step` or `err` pulse is emitted that cycle.
- **Wrap-around:**
  - Code: 2^W−1 → 0 counts as a legal +1, and 0 → 2^W−1 as a legal −1.
  - `pos`: wraps modulo 2^P with no flag (0x7FFF +1 → 0x8000 for P=16).
- **Reset mid-operation:** asynchronous return to the reset values above, then re-entry through INIT.

## Timing
- **Latency:** a `g_in` value stable before edge E0 is sampled into `s1` at E0 and `s2` at E1. `bin`, `step`, `dir`, `pos`, `err` and `err_cnt` update at E2. That is 2 cycles of latency after capture.
- **Pulse width:** `step` and `err` are exactly one cycle wide per accepted change.
- **Throughput:** back-to-back changes one cycle apart each produce their own pulse.
- **Sender requirement:** the sender must hold each code for at least one `clk` period. Faster changes are undefined and will typically show up as `err`.
- **Exit from INIT:** the TRACK transition and the `prev` load both happen at the 2nd rising edge after `rst_n` deasserts.
- **`fault`:** asserts on the same edge as the first `err` pulse. It deasserts on the edge where `clr` is sampled.

## Test plan
- **Reset/INIT:** hold `g_in`=0110 (value 4) through reset and release. Required: `bin`=4 after 2 cycles, `step`=0, `pos`=0, no `err`.
- **Up sweep:** from 0, drive the Gray sequence 0000,0001,0011,0010,0110 (one value every 4 cycles). Required: four `step` pulses, each with `dir`=1; `bin` ends at 4; `pos`=4; each pulse lands 2 cycles after the change.
- **Wrap:** from `bin`=15 (1000) drive 0000, then back to 1000. Required: first change gives a step with `dir`=1 and `pos`+1; second gives a step with `dir`=0 and `pos`−1.
- **Illegal jump:** from 0000 drive 0011 (0→2). Required: one `err` pulse, `fault`=1, `err_cnt`=1, `bin`=2, `pos` unchanged. A following 0010 (→3) gives no `step`.
- **Clear vs. event:** while in FAULT, assert `clr` for one cycle in the same cycle that a legal change reaches decode. Required: `fault`=0, `pos`=0, `err_cnt`=0, no `step` that cycle. Next legal change pulses `step` with `pos`=±1.
- **Saturation and async reset:** force 300 illegal jumps. Required: `err_cnt` holds at 255. Pull `rst_n` low mid-stream. Required: all outputs return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gtb_tracker.sv
// Gray-to-binary receive tracker: 2-flop sync, Gray decode, step/error
// classification, signed position accumulator and saturating error count.
module gtb_tracker #(
    parameter int W = 4,
    parameter int P = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] g_in,
    input  logic         clr,
    output logic [W-1:0] bin,
    output logic         step,
    output logic         dir,
    output logic [P-1:0] pos,
    output logic         err,
    output logic         fault,
    output logic [7:0]   err_cnt
);

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    localparam logic [W-1:0] ONE_W = W'(1);
    localparam logic [W-1:0] ALL_W = '1;
    localparam logic [P-1:0] ONE_P = P'(1);

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t       state, state_n;
    logic [1:0]   flush, flush_n;
    logic [W-1:0] s1, s2, cur, landing, prev, prev_n, diff;
    logic [P-1:0] pos_n;
    logic [7:0]   cnt_n;
    logic         step_n, err_n, dir_n;
    logic         up, dn, chg;

    assign cur     = g2b(s2);
    assign landing = g2b(s1);
    assign diff    = cur - prev;
    assign up      = (diff == ONE_W);
    assign dn      = (diff == ALL_W);
    assign chg     = (diff != '0);
    assign bin     = prev;
    assign fault   = (state == FAULT);

    always_comb begin
        state_n = state;
        flush_n = flush;
        prev_n  = prev;
        pos_n   = pos;
        cnt_n   = err_cnt;
        step_n  = 1'b0;
        err_n   = 1'b0;
        dir_n   = dir;
        unique case (state)
            INIT: begin
                // Take the value entering s2 now, so the first TRACK
                // compare is against fully flushed data.
                if (flush == 2'd1) begin
                    prev_n  = landing;
                    flush_n = 2'd0;
                    state_n = TRACK;
                end else begin
                    flush_n = flush + 2'd1;
                end
            end
            TRACK, FAULT: begin
                if (clr) begin
                    pos_n   = '0;
                    cnt_n   = '0;
                    prev_n  = cur;
                    state_n = TRACK;
                end else if (chg) begin
                    prev_n = cur;
                    if (up || dn) begin
                        if (state == TRACK) begin
                            step_n = 1'b1;
                            dir_n  = up;
                            pos_n  = up ? pos + ONE_P : pos - ONE_P;
                        end
                    end else begin
                        err_n   = 1'b1;
                        state_n = FAULT;
                        if (err_cnt != 8'hFF) begin
                            cnt_n = err_cnt + 8'd1;
                        end
                    end
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            state   <= INIT;
            flush   <= '0;
            prev    <= '0;
            pos     <= '0;
            err_cnt <= '0;
            step    <= 1'b0;
            err     <= 1'b0;
            dir     <= 1'b0;
        end else begin
            s1      <= g_in;
            s2      <= s1;
            state   <= state_n;
            flush   <= flush_n;
            prev    <= prev_n;
            pos     <= pos_n;
            err_cnt <= cnt_n;
            step    <= step_n;
            err     <= err_n;
            dir     <= dir_n;
        end
    end

endmodule

// File: tb/tb_gtb_tracker.sv
// Scoreboard bench for gtb_tracker: model pushes expected output
// snapshots at drive time, monitor pops them on the due cycle.
module tb_gtb_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  g_in = 4'b0110;
    logic        clr = 1'b0;
    logic [3:0]  bin;
    logic        step, dir, err, fault;
    logic [15:0] pos;
    logic [7:0]  err_cnt;

    gtb_tracker #(.W(4), .P(16)) dut (
        .clk(clk), .rst_n(rst_n), .g_in(g_in), .clr(clr),
        .bin(bin), .step(step), .dir(dir), .pos(pos),
        .err(err), .fault(fault), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          b;
        bit          step;
        bit          dir;
        logic [15:0] pos;
        bit          err;
        bit          fault;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int          mb;
    logic [15:0] mpos;
    bit          mdir, mfault;
    int          mcnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("bin", bin, e.b);
            chk("step", step, e.step);
            chk("dir", dir, e.dir);
            chk("pos", pos, e.pos);
            chk("err", err, e.err);
            chk("fault", fault, e.fault);
            chk("err_cnt", err_cnt, e.cnt);
        end
    end

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic push(input int due, input bit s, input bit e);
        exp_t x;
        x.due = due; x.b = mb; x.step = s; x.dir = mdir; x.pos = mpos;
        x.err = e; x.fault = mfault; x.cnt = mcnt;
        q.push_back(x);
    endtask

    task automatic drive(input int b);
        bit up, dn, s, e;
        int n;
        @(negedge clk);
        n = cyc;
        g_in = gray(b);
        up = (b == ((mb + 1) % 16));
        dn = (b == ((mb + 15) % 16));
        s = 0; e = 0;
        if (b != mb) begin
            if (!up && !dn) begin
                e = 1;
                mfault = 1;
                if (mcnt < 255) mcnt++;
            end else if (!mfault) begin
                s = 1;
                mdir = up;
                mpos = up ? mpos + 16'd1 : mpos - 16'd1;
            end
            mb = b;
        end
        push(n + 3, s, e);
        push(n + 4, 0, 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"}, bin, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_pos"}, pos, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
    endtask

    initial begin
        int n;
        int lastb;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_bin", bin, 4);
        chk("init_step", step, 0);
        chk("init_pos", pos, 0);
        chk("init_err", err, 0);
        mb = 4; mpos = 0; mdir = 0; mcnt = 0; mfault = 0;

        for (int b = 3; b >= 0; b--) drive(b);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mpos = 0;
        chk("clr_pos", pos, 0);
        chk("clr_dir_held", dir, 0);

        for (int b = 1; b <= 15; b++) drive(b);
        drive(0);
        drive(15);
        drive(0);
        chk("wrap_pos", pos, 16);

        drive(2);
        drive(3);

        @(negedge clk);
        n = cyc;
        g_in = gray(4);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        mb = 4; mpos = 0; mcnt = 0; mfault = 0;
        push(n + 3, 0, 0);
        push(n + 4, 0, 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        drive(5);
        chk("post_clr_pos", pos, 1);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            g_in = (i % 2 == 0) ? gray(9) : gray(5);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sat_cnt", err_cnt, 255);
        chk("sat_fault", fault, 1);

        @(negedge clk);
        g_in = gray(9);
        lastb = 9;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reinit_bin", bin, lastb);
        chk("reinit_err", err, 0);
        chk("reinit_fault", fault, 0);
        repeat (3) @(negedge clk);
        chk("reinit_quiet", err, 0);

        chk("sb_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
